// File: rtl/fetch_unit.sv
// Instruction fetch / program-counter stage feeding the decode LUT of the
// single-cycle MIPS datapath: PC register, imem handshake, next-PC select, faults.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        IsJump,
    input  logic        IsJAL,
    input  logic        IsJR,
    input  logic        IsBranch,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] inst,
    output logic [5:0]  OP,
    output logic [5:0]  FUNCT,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic        inst_valid,
    output logic        fault,
    output logic [1:0]  fault_code
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t             state;
    logic [7:0]         wait_cnt;
    logic signed [31:0] br_off;
    logic [31:0]        next_pc;
    logic               jr_misaligned;
    logic               link_unused;

    assign pc_plus4   = pc + 32'd4;
    assign imem_addr  = pc;
    assign imem_req   = (state == S_FETCH) && !reset;
    assign inst_valid = (state == S_EXEC);

    assign OP    = inst[31:26];
    assign rs    = inst[25:21];
    assign rt    = inst[20:16];
    assign rd    = inst[15:11];
    assign imm   = inst[15:0];
    assign FUNCT = inst[5:0];

    // JAL only selects pc_plus4 as the link value downstream; the target is the J target.
    assign link_unused = IsJAL;

    assign br_off        = {{14{inst[15]}}, inst[15:0], 2'b00};
    assign jr_misaligned = IsJR && (jr_target[1:0] != 2'b00);

    always_comb begin
        next_pc = pc_plus4;
        if (IsJR)
            next_pc = jr_target;
        else if (IsJump)
            next_pc = {pc_plus4[31:28], inst[25:0], 2'b00};
        else if (IsBranch)
            next_pc = pc_plus4 + $unsigned(br_off);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            inst       <= 32'd0;
            wait_cnt   <= 8'd0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            case (state)
                S_FETCH: begin
                    wait_cnt <= 8'd0;
                    state    <= S_WAIT;
                end
                // The response window is TIMEOUT WAIT cycles; the last one still accepts data.
                S_WAIT: begin
                    if (imem_valid) begin
                        inst  <= imem_data;
                        state <= S_EXEC;
                    end else if (wait_cnt == WAIT_LAST) begin
                        if (!fault) begin
                            fault      <= 1'b1;
                            fault_code <= 2'b01;
                        end
                        state <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        if (jr_misaligned) begin
                            if (!fault) begin
                                fault      <= 1'b1;
                                fault_code <= 2'b10;
                            end
                            state <= S_HALT;
                        end else begin
                            pc    <= next_pc;
                            state <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch and program-counter stage directly upstream of the instruction decode LUT in the single-cycle MIPS datapath. It holds the PC and requests instruction words from instruction memory over a valid handshake. It registers each fetched word and presents its decoded fields (OP, FUNCT, register specifiers, immediate) to the LUT. It computes the next PC from the LUT's IsJump/IsJAL/IsJR/IsBranch outputs and flags fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles to wait for imem_valid before a timeout fault (range 1..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_addr  output  32  fetch address; equals pc
imem_req  output  1  one-cycle fetch request pulse
imem_valid  input  1  imem_data valid this cycle
imem_data  input  32  instruction word from instruction memory
stall  input  1  hold the current instruction (downstream not ready)
IsJump  input  1  from LUT: J or JAL
IsJAL  input  1  from LUT: JAL (link uses pc_plus4)
IsJR  input  1  from LUT: jump register
IsBranch  input  1  from LUT: branch taken (already qualified by zero)
jr_target  input  32  register-file read value for JR
pc  output  32  address of the current instruction
pc_plus4  output  32  pc + 4, link value for JAL
inst  output  32  registered instruction word
OP  output  6  inst[31:26]
FUNCT  output  6  inst[5:0]
rs  output  5  inst[25:21]
rt  output  5  inst[20:16]
rd  output  5  inst[15:11]
imm  output  16  inst[15:0]
inst_valid  output  1  inst and fields valid; LUT outputs are meaningful
fault  output  1  sticky; fetch halted
fault_code  output  2  00 none, 01 imem timeout, 10 misaligned JR target

Behaviour:
- Reset (reset=1 at an edge, any state): pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, fault=0, fault_code=00, timeout counter=0, state=FETCH. Reset overrides every other input, including in HALT.
- pc_plus4 = pc + 4, combinational, modulo 2^32. Field outputs are combinational slices of inst.
- FSM states: FETCH, WAIT, EXEC, HALT.
- FETCH: imem_req=1 for exactly this cycle, imem_addr=pc. Next state is WAIT and the counter is cleared.
- WAIT: imem_req=0. imem_valid is sampled only in WAIT.
  - imem_valid=1: inst<=imem_data, next state EXEC.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with imem_valid still 0: fault<=1, fault_code<=01, next state HALT.
  - imem_valid asserted during FETCH or EXEC is ignored.
- Minimum latency: req in cycle N, valid in N+1, inst_valid=1 in N+2.
- EXEC: inst_valid=1.
  - stall=1: hold pc, inst and state.
  - stall=0: pc<=next_pc, state<=FETCH, inst_valid drops next cycle. Each instruction is in EXEC for at least one cycle.
- next_pc priority, highest first:
  - IsJR: jr_target. If jr_target[1:0]!=00, then fault<=1, fault_code<=10, pc is unchanged and the next state is HALT.
  - IsJump (including JAL): {pc_plus4[31:28], inst[25:0], 2'b00}
  - IsBranch: pc_plus4 + ({{14{imm[15]}}, imm, 2'b00}), wraps modulo 2^32
  - else: pc_plus4
- IsJAL does not affect next_pc; it only qualifies the link value on pc_plus4, which is valid whenever inst_valid=1.
- HALT: imem_req=0, inst_valid=0, and pc and inst hold. Only reset exits HALT. fault_code holds the first fault only.
- Control inputs (Is*, jr_target, stall) are ignored outside EXEC.
- Reset asserted mid-WAIT discards any pending response. An imem_valid in the cycle after reset is ignored, because the state is then FETCH.

Test Plan:
- Sequential fetch: reset with RESET_PC=0, memory returns after 1 cycle, no control flags set -> imem_addr sequence 0,4,8; inst_valid high 1 cycle per 3; imem_req 1 cycle per fetch.
- Jump/JAL: at pc=0x1000_0010, inst=0x0C00_0040 with IsJump=1 and IsJAL=1 -> next imem_addr=0x1000_0100; pc_plus4=0x1000_0014 while inst_valid.
- Branch backward: at pc=0x20, imm=16'hFFFC with IsBranch=1 -> next pc=0x14. Second case: pc=0xFFFF_FFF8, imm=1 -> pc=0x0000_0000 (wrap).
- JR: jr_target=0x40 -> pc=0x40. jr_target=0x42 -> fault=1, fault_code=10, pc holds, and no further imem_req until reset.
- Timeout: TIMEOUT=4, imem_valid never asserted -> fault=1 and fault_code=01 in the 4th WAIT cycle. A late imem_valid is ignored. Reset then restarts at RESET_PC.
- Stall and reset: stall=1 for 5 EXEC cycles -> inst and pc stable, inst_valid=1 throughout. Then reset in WAIT with imem_valid in the next cycle -> pc=RESET_PC, inst=0, inst_valid=0.
